// File: rtl/uart_tx_arbiter_pkg.sv
// Shared ids, state encoding and defaults for the UART TX arbiter and its requesters.
package uart_tx_arbiter_pkg;

  localparam int REQ_GEN   = 0;
  localparam int REQ_INPUT = 1;
  localparam int REQ_DISP  = 2;
  localparam int REQ_CALC  = 3;

  localparam int TX_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    TXA_IDLE  = 2'd0,
    TXA_OWNED = 2'd1,
    TXA_DRAIN = 2'd2
  } txa_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module uart_tx_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] w_cand;

  // Walk from farthest to nearest so the nearest set bit after ptr overwrites the rest.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among lock-holding requesters: round-robin grant,
// start forwarding for the owner, drop reporting for others, and a stall watchdog.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = TX_TIMEOUT_CYCLES,
  parameter int TO_WIDTH       = 13
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_lock,
  input  logic [N_REQ-1:0]            req_tx_start,
  input  logic [8*N_REQ-1:0]          req_tx_data,
  output logic [N_REQ-1:0]            req_tx_busy,
  output logic [N_REQ-1:0]            grant,
  output logic                        uart_tx_start,
  output logic [7:0]                  uart_tx_data,
  input  logic                        uart_tx_busy,
  output logic                        timeout_pulse,
  output logic [$clog2(N_REQ)-1:0]    timeout_id,
  output logic                        drop_pulse,
  output txa_state_e                  dbg_state
);

  localparam int IW = $clog2(N_REQ);

  txa_state_e          r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [N_REQ-1:0]    r_mask;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_timeout_id;
  logic [TO_WIDTH-1:0] r_wd;
  logic [1:0]          r_shadow;
  logic                r_uart_start;
  logic [7:0]          r_uart_data;
  logic                r_timeout_pulse;
  logic                r_drop;

  logic                w_owned;
  logic                w_shadow;
  logic                w_path_busy;
  logic [N_REQ-1:0]    w_owner_oh;
  logic [N_REQ-1:0]    w_busy;
  logic [N_REQ-1:0]    w_eligible;
  logic                w_accept;
  logic                w_release;
  logic                w_timeout;
  logic                w_drop;
  logic [7:0]          w_owner_data;
  logic [IW-1:0]       w_win;
  logic                w_win_valid;

  // Handshake: a requester may pulse req_tx_start only while its req_tx_busy is 0;
  // that cycle is the transfer. Busy covers the forwarding register and the UART's
  // one-cycle busy-rise latency through the shadow counter.
  assign w_owned      = (r_state == TXA_OWNED);
  assign w_shadow     = (r_shadow != 2'd0);
  assign w_path_busy  = uart_tx_busy | w_shadow;
  assign w_owner_oh   = w_owned ? (N_REQ'(1) << r_owner) : '0;
  assign w_eligible   = req_lock & ~r_mask;
  assign w_owner_data = req_tx_data[{r_owner, 3'b000} +: 8];

  always_comb begin
    w_busy = '1;
    if (w_owned) w_busy[r_owner] = w_path_busy;
  end

  assign w_accept  = w_owned & req_tx_start[r_owner] & ~w_path_busy;
  assign w_release = w_owned & ~req_lock[r_owner];
  assign w_timeout = w_owned & ~w_release & ~w_accept &
                     (r_wd == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign w_drop    = |(req_tx_start & ~w_owner_oh);

  uart_tx_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .i_req   (w_eligible),
    .i_ptr   (r_ptr),
    .o_idx   (w_win),
    .o_valid (w_win_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= TXA_IDLE;
      r_grant         <= '0;
      r_mask          <= '0;
      r_owner         <= '0;
      r_ptr           <= IW'(N_REQ - 1);
      r_timeout_id    <= '0;
      r_wd            <= '0;
      r_shadow        <= 2'd0;
      r_uart_start    <= 1'b0;
      r_uart_data     <= 8'h00;
      r_timeout_pulse <= 1'b0;
      r_drop          <= 1'b0;
    end else begin
      r_uart_start    <= w_accept;
      r_drop          <= w_drop;
      r_timeout_pulse <= w_timeout;
      if (w_accept)  r_uart_data  <= w_owner_data;
      if (w_timeout) r_timeout_id <= r_owner;
      // A revoked requester stays masked until it lets go of its lock.
      r_mask <= (r_mask | (w_timeout ? w_owner_oh : '0)) & req_lock;

      if (w_accept)           r_shadow <= 2'd2;
      else if (w_shadow)      r_shadow <= r_shadow - 2'd1;

      case (r_state)
        TXA_IDLE: begin
          if (w_win_valid) begin
            r_grant <= N_REQ'(1) << w_win;
            r_owner <= w_win;
            r_ptr   <= w_win;
            r_wd    <= '0;
            r_state <= TXA_OWNED;
          end
        end
        TXA_OWNED: begin
          if (w_accept || w_path_busy) r_wd <= '0;
          else                         r_wd <= r_wd + TO_WIDTH'(1);
          if (w_release || w_timeout) begin
            r_grant <= '0;
            r_state <= TXA_DRAIN;
          end
        end
        TXA_DRAIN: begin
          if (!w_path_busy) r_state <= TXA_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_state <= TXA_IDLE;
        end
      endcase
    end
  end

  assign req_tx_busy   = w_busy;
  assign grant         = r_grant;
  assign uart_tx_start = r_uart_start;
  assign uart_tx_data  = r_uart_data;
  assign timeout_pulse = r_timeout_pulse;
  assign timeout_id    = r_timeout_id;
  assign drop_pulse    = r_drop;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART busy model and byte scoreboard.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N        = 4;
  localparam int TO       = 16;
  localparam int UART_CYC = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] lock = '0;
  logic [3:0] start = '0;
  logic [31:0] data = '0;

  logic [3:0] req_tx_busy;
  logic [3:0] grant;
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       timeout_pulse;
  logic [1:0] timeout_id;
  logic       drop_pulse;
  txa_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  int overlap_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO), .TO_WIDTH(13)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_lock      (lock),
    .req_tx_start  (start),
    .req_tx_data   (data),
    .req_tx_busy   (req_tx_busy),
    .grant         (grant),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .timeout_pulse (timeout_pulse),
    .timeout_id    (timeout_id),
    .drop_pulse    (drop_pulse),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // UART model: busy rises the cycle after a start and lasts UART_CYC cycles.
  assign uart_tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (!rst_n) begin
      busy_cnt <= 0;
    end else if (uart_tx_start) begin
      busy_cnt <= UART_CYC;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL uart_byte: got %h, expected no byte", uart_tx_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (uart_tx_data !== sb_exp) begin
          errors++;
          $display("FAIL uart_byte: got %h, expected %h", uart_tx_data, sb_exp);
        end
      end
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && (($countones(grant) > 1) || $isunknown(grant))) overlap_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lock  = '0;
    start = '0;
    data  = '0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_byte(input int id, input logic [7:0] b);
    int n;
    n = 0;
    while (req_tx_busy[id] && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL send_wait: busy[%0d] still 1 after %0d cycles, required 0", id, n);
    end
    start[id] = 1'b1;
    data[8*id +: 8] = b;
    tick();
    start[id] = 1'b0;
  endtask

  task automatic wait_uart_idle(input int id);
    int n;
    n = 0;
    while ((uart_tx_busy || req_tx_busy[id]) && n < 100) begin
      tick();
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b, required 0000", grant); end
    checks++; if (req_tx_busy !== 4'b1111) begin errors++; $display("FAIL reset_busy: got %b, required 1111", req_tx_busy); end
    checks++; if (uart_tx_start !== 1'b0 || uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_uart: got start=%b data=%h, required 0/00", uart_tx_start, uart_tx_data); end
    checks++; if (timeout_pulse !== 1'b0 || timeout_id !== 2'd0 || drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_flags: got to=%b id=%0d drop=%b, required 0/0/0", timeout_pulse, timeout_id, drop_pulse); end
    checks++; if (dbg_state !== TXA_IDLE) begin errors++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, TXA_IDLE); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_owner();
    logic [7:0] msg [3] = '{8'h41, 8'h42, 8'h0A};
    int n;
    do_reset();
    lock[REQ_GEN] = 1'b1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_pregrant: got %b, required 0000", grant); end
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b, required 0001", grant); end
    checks++; if (req_tx_busy !== 4'b1110) begin errors++; $display("FAIL single_busy_free: got %b, required 1110", req_tx_busy); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(msg[i]);
      send_byte(REQ_GEN, msg[i]);
      checks++; if (uart_tx_start !== 1'b1 || uart_tx_data !== msg[i]) begin errors++; $display("FAIL single_fwd%0d: got start=%b data=%h, required 1/%h", i, uart_tx_start, uart_tx_data, msg[i]); end
      checks++; if (req_tx_busy !== 4'b1111) begin errors++; $display("FAIL single_busy_shadow%0d: got %b, required 1111", i, req_tx_busy); end
    end
    wait_uart_idle(REQ_GEN);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_stream: %0d bytes not seen, required 0", exp_q.size()); end
    lock = '0;
    n = 0;
    while (dbg_state != TXA_IDLE && n < 50) begin tick(); n++; end
    checks++; if (grant !== 4'b0000 || dbg_state !== TXA_IDLE) begin errors++; $display("FAIL single_release: got grant=%b state=%0d, required 0000/IDLE", grant, dbg_state); end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 2, 3, 0};
    int n;
    do_reset();
    overlap_cnt = 0;
    lock = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (grant == 4'b0000 && n < 50) begin tick(); n++; end
      checks++; if (grant !== (4'b0001 << order[k])) begin errors++; $display("FAIL rr_grant%0d: got %b, required %b", k, grant, 4'b0001 << order[k]); end
      exp_q.push_back(8'h30 + 8'(k));
      send_byte(order[k], 8'h30 + 8'(k));
      lock[order[k]] = 1'b0;
      tick();
      lock[order[k]] = 1'b1;
    end
    lock = '0;
    wait_uart_idle(0);
    tick();
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_stream: %0d bytes not seen, required 0", exp_q.size()); end
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL rr_onehot: %0d cycles with multiple/X grant, required 0", overlap_cnt); end
  endtask

  task automatic test_handover();
    int cyc;
    int last_busy;
    do_reset();
    lock = 4'b0110;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL ho_grant1: got %b, required 0010", grant); end
    exp_q.push_back(8'h68);
    start[1] = 1'b1;
    data[15:8] = 8'h68;
    lock[1] = 1'b0;
    tick();
    start[1] = 1'b0;
    checks++; if (uart_tx_start !== 1'b1 || uart_tx_data !== 8'h68) begin errors++; $display("FAIL ho_fwd: got start=%b data=%h, required 1/68", uart_tx_start, uart_tx_data); end
    checks++; if (grant !== 4'b0000 || dbg_state !== TXA_DRAIN) begin errors++; $display("FAIL ho_drain: got grant=%b state=%0d, required 0000/DRAIN", grant, dbg_state); end
    cyc = 0;
    last_busy = -1;
    while (grant == 4'b0000 && cyc < 50) begin
      if (uart_tx_busy) last_busy = cyc;
      tick();
      cyc++;
    end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL ho_grant2: got %b, required 0100", grant); end
    checks++; if (last_busy != 5 || cyc != last_busy + 3) begin errors++; $display("FAIL ho_timing: got last_busy=%0d grant_cycle=%0d, required 5/8", last_busy, cyc); end
    lock = '0;
    tick();
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ho_stream: %0d bytes not seen, required 0", exp_q.size()); end
  endtask

  task automatic test_non_owner();
    int n;
    do_reset();
    lock = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL no_grant: got %b, required 0001", grant); end
    start[REQ_CALC] = 1'b1;
    data[31:24] = 8'h55;
    tick();
    start[REQ_CALC] = 1'b0;
    checks++; if (drop_pulse !== 1'b1 || uart_tx_start !== 1'b0) begin errors++; $display("FAIL no_drop: got drop=%b start=%b, required 1/0", drop_pulse, uart_tx_start); end
    tick();
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL no_drop_len: got %b, required 0", drop_pulse); end
    exp_q.push_back(8'h5A);
    send_byte(0, 8'h5A);
    checks++; if (uart_tx_start !== 1'b1 || uart_tx_data !== 8'h5A) begin errors++; $display("FAIL no_owner_fwd: got start=%b data=%h, required 1/5a", uart_tx_start, uart_tx_data); end
    start[0] = 1'b1;
    data[7:0] = 8'h21;
    tick();
    start[0] = 1'b0;
    checks++; if (drop_pulse !== 1'b0 || uart_tx_start !== 1'b0 || uart_tx_data !== 8'h5A) begin errors++; $display("FAIL no_busy_start: got drop=%b start=%b data=%h, required 0/0/5a", drop_pulse, uart_tx_start, uart_tx_data); end
    wait_uart_idle(0);
    lock = '0;
    n = 0;
    while (dbg_state != TXA_IDLE && n < 50) begin tick(); n++; end
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    checks++; if (drop_pulse !== 1'b1 || uart_tx_start !== 1'b0) begin errors++; $display("FAIL no_idle_drop: got drop=%b start=%b, required 1/0", drop_pulse, uart_tx_start); end
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL no_stream: %0d bytes not seen, required 0", exp_q.size()); end
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
    lock = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL wd_grant: got %b, required 0100", grant); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        checks++; if (timeout_pulse !== 1'b0 || grant !== 4'b0100) begin errors++; $display("FAIL wd_early: got to=%b grant=%b, required 0/0100", timeout_pulse, grant); end
      end
    end
    checks++; if (timeout_pulse !== 1'b1 || timeout_id !== 2'd2 || grant !== 4'b0000) begin errors++; $display("FAIL wd_fire: got to=%b id=%0d grant=%b, required 1/2/0000", timeout_pulse, timeout_id, grant); end
    lock[1] = 1'b1;
    tick();
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL wd_pulse_len: got %b, required 0", timeout_pulse); end
    n = 0;
    while (grant == 4'b0000 && n < 50) begin tick(); n++; end
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wd_other: got %b, required 0010", grant); end
    lock[1] = 1'b0;
    repeat (4) tick();
    checks++; if (grant !== 4'b0000 || dbg_state !== TXA_IDLE) begin errors++; $display("FAIL wd_masked: got grant=%b state=%0d, required 0000/IDLE", grant, dbg_state); end
    checks++; if (timeout_id !== 2'd2) begin errors++; $display("FAIL wd_id_hold: got %0d, required 2", timeout_id); end
    lock[2] = 1'b0;
    tick();
    lock[2] = 1'b1;
    n = 0;
    while (grant == 4'b0000 && n < 50) begin tick(); n++; end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL wd_regrant: got %b, required 0100", grant); end
    lock = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    lock = 4'b0001;
    tick();
    send_byte(0, 8'h4D);
    checks++; if (uart_tx_start !== 1'b1 || req_tx_busy !== 4'b1111) begin errors++; $display("FAIL rm_setup: got start=%b busy=%b, required 1/1111", uart_tx_start, req_tx_busy); end
    rst_n = 1'b0;
    lock = '0;
    #1;
    checks++; if (grant !== 4'b0000 || req_tx_busy !== 4'b1111 || uart_tx_start !== 1'b0) begin errors++; $display("FAIL rm_async: got grant=%b busy=%b start=%b, required 0000/1111/0", grant, req_tx_busy, uart_tx_start); end
    checks++; if (dbg_state !== TXA_IDLE) begin errors++; $display("FAIL rm_state: got %0d, required IDLE", dbg_state); end
    tick();
    rst_n = 1'b1;
    lock = 4'b1001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rm_ptr: got %b, required 0001", grant); end
    lock = '0;
    tick();
    tick();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_single_owner();
    test_round_robin();
    test_handover();
    test_non_owner();
    test_watchdog();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

endmodule
